// File: rtl/mips_stage_mem_access.sv
// MEM stage of the 5-stage MIPS pipeline: drives loads/stores onto a valid/ready data bus and stalls upstream while an access is outstanding.
// Optional build macro MIPS_STAGE_MEM_ALIGN_CHECK_EN faults misaligned half/word accesses without issuing them.
`timescale 1ns/1ps
module mips_stage_mem_access #(
  parameter int DELAYED = 1,
  parameter int TIMEOUT = 255
) (
  input  logic [1:0]  ctrl,
  input  logic        inValid,
  input  logic [31:0] inAluResult,
  input  logic [31:0] inStoreData,
  input  logic [4:0]  inDest,
  input  logic        inMemRead,
  input  logic        inMemWrite,
  input  logic [1:0]  inSize,
  input  logic        inSigned,
  output logic        stall,
  output logic        memReqValid,
  input  logic        memReqReady,
  output logic        memReqWrite,
  output logic [31:0] memReqAddr,
  output logic [3:0]  memReqByteEn,
  output logic [31:0] memReqData,
  input  logic        memRespValid,
  input  logic [31:0] memRespData,
  output logic        outValid,
  output logic [31:0] outResult,
  output logic [4:0]  outDest,
  output logic        outFault,
  output logic [4:0]  hazDest,
  output logic        hazLoadPending
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  // Bus handshake: a request transfers on the cycle memReqValid && memReqReady are
  // both high; request fields stay frozen from capture until that cycle. A response
  // is a single-cycle memRespValid pulse, accepted only while in ST_WAIT.
  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_addr;
  logic [1:0]  r_lane;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_write;
  logic        r_is_load;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [4:0]  r_dest;
  logic        r_out_valid;
  logic [31:0] r_out_result;
  logic [4:0]  r_out_dest;
  logic        r_out_fault;

  logic        w_clk;
  logic        w_rst;
  logic        w_is_mem;
  logic [1:0]  w_size_eff;
  logic        w_misalign;
  logic        w_idle;
  logic        w_accept_pass;
  logic        w_accept_mem;
  logic        w_accept_fault;
  logic        w_resp;
  logic        w_timeout;
  logic [CW-1:0] w_cnt_next;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic        w_done_valid;
  logic [31:0] w_done_result;
  logic [4:0]  w_done_dest;
  logic        w_done_fault;

  assign w_clk      = ctrl[1];
  assign w_rst      = ctrl[0];
  assign w_is_mem   = inMemRead | inMemWrite;
  // Size 3 is folded into word so later decode only sees byte/half/word.
  assign w_size_eff = (inSize == 2'd3) ? 2'd2 : inSize;

`ifdef MIPS_STAGE_MEM_ALIGN_CHECK_EN
  assign w_misalign = ((w_size_eff == 2'd1) && inAluResult[0]) ||
                      ((w_size_eff == 2'd2) && (inAluResult[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_idle         = (r_state == ST_IDLE) && !w_rst;
  assign w_accept_pass  = w_idle && inValid && !w_is_mem;
  assign w_accept_mem   = w_idle && inValid && w_is_mem;
  assign w_accept_fault = w_accept_mem && w_misalign;
  assign w_resp         = (r_state == ST_WAIT) && memRespValid;
  assign w_cnt_next     = r_cnt + 1'b1;
  // A response arriving on the expiry cycle wins over the timeout.
  assign w_timeout      = (r_state == ST_WAIT) && !memRespValid &&
                          (TIMEOUT != 0) && (w_cnt_next == TO_V);

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = 32'd0;
    case (w_size_eff)
      2'd0: begin
        w_be    = 4'b0001 << inAluResult[1:0];
        w_wdata = {4{inStoreData[7:0]}};
      end
      2'd1: begin
        w_be    = inAluResult[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{inStoreData[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = inStoreData;
      end
    endcase
  end

  always_comb begin
    w_byte = 8'd0;
    case (r_lane)
      2'd0:    w_byte = memRespData[7:0];
      2'd1:    w_byte = memRespData[15:8];
      2'd2:    w_byte = memRespData[23:16];
      default: w_byte = memRespData[31:24];
    endcase
    w_half = r_lane[1] ? memRespData[31:16] : memRespData[15:0];
    case (r_size)
      2'd0:    w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
      2'd1:    w_load_data = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load_data = memRespData;
    endcase
  end

  // Completion bundle: pass-through, load return, store ack, timeout or alignment fault.
  always_comb begin
    w_done_valid  = w_resp || w_timeout || w_accept_pass || w_accept_fault;
    w_done_fault  = w_timeout || w_accept_fault;
    w_done_result = 32'd0;
    w_done_dest   = 5'd0;
    if (w_accept_pass) begin
      w_done_result = inAluResult;
      w_done_dest   = inDest;
    end else if (w_resp && !r_write) begin
      w_done_result = w_load_data;
      w_done_dest   = r_dest;
    end
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_addr       <= 32'd0;
      r_lane       <= 2'd0;
      r_be         <= 4'd0;
      r_wdata      <= 32'd0;
      r_write      <= 1'b0;
      r_is_load    <= 1'b0;
      r_size       <= 2'd0;
      r_signed     <= 1'b0;
      r_dest       <= 5'd0;
      r_out_valid  <= 1'b0;
      r_out_result <= 32'd0;
      r_out_dest   <= 5'd0;
      r_out_fault  <= 1'b0;
    end else begin
      r_out_valid <= w_done_valid;
      r_out_fault <= w_done_fault;
      if (w_done_valid) begin
        r_out_result <= w_done_result;
        r_out_dest   <= w_done_dest;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept_mem && !w_accept_fault) begin
            r_addr    <= {inAluResult[31:2], 2'b00};
            r_lane    <= inAluResult[1:0];
            r_be      <= w_be;
            r_wdata   <= w_wdata;
            r_write   <= inMemWrite;
            r_is_load <= !inMemWrite;
            r_size    <= w_size_eff;
            r_signed  <= inSigned;
            r_dest    <= inDest;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (memReqReady) begin
            r_cnt   <= '0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (memRespValid || w_timeout) r_state <= ST_IDLE;
          else r_cnt <= w_cnt_next;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign memReqValid  = (r_state == ST_ISSUE);
  assign memReqWrite  = r_write;
  assign memReqAddr   = r_addr;
  assign memReqByteEn = r_be;
  assign memReqData   = r_wdata;

  // Unregistered variant releases stall in the completing cycle itself.
  assign stall = w_accept_mem || (r_state == ST_ISSUE) ||
                 ((r_state == ST_WAIT) && ((DELAYED != 0) || !(memRespValid || w_timeout)));

  assign hazLoadPending = (w_accept_mem && !inMemWrite && !w_misalign) ||
                          (((r_state == ST_ISSUE) || (r_state == ST_WAIT)) && r_is_load);
  assign hazDest = !hazLoadPending ? 5'd0 : ((r_state == ST_IDLE) ? inDest : r_dest);

  assign outValid  = (DELAYED != 0) ? r_out_valid  : w_done_valid;
  assign outResult = (DELAYED != 0) ? r_out_result : w_done_result;
  assign outDest   = (DELAYED != 0) ? r_out_dest   : w_done_dest;
  assign outFault  = (DELAYED != 0) ? r_out_fault  : w_done_fault;

endmodule

// File: tb/tb_mips_stage_mem_access.sv
// Directed-vector bench for mips_stage_mem_access (DELAYED=1, TIMEOUT=4).
`timescale 1ns/1ps
module tb_mips_stage_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inValid = 1'b0;
  logic [31:0] inAluResult = '0;
  logic [31:0] inStoreData = '0;
  logic [4:0]  inDest = '0;
  logic        inMemRead = 1'b0;
  logic        inMemWrite = 1'b0;
  logic [1:0]  inSize = '0;
  logic        inSigned = 1'b0;
  logic        memReqReady = 1'b0;
  logic        memRespValid = 1'b0;
  logic [31:0] memRespData = '0;
  logic        stall;
  logic        memReqValid;
  logic        memReqWrite;
  logic [31:0] memReqAddr;
  logic [3:0]  memReqByteEn;
  logic [31:0] memReqData;
  logic        outValid;
  logic [31:0] outResult;
  logic [4:0]  outDest;
  logic        outFault;
  logic [4:0]  hazDest;
  logic        hazLoadPending;

  int chk_cnt = 0;
  int fail_cnt = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt + 1);
    $fatal(1, "watchdog");
  end

  mips_stage_mem_access #(.DELAYED(1), .TIMEOUT(4)) dut (
    .ctrl({clk, rst}),
    .inValid(inValid),
    .inAluResult(inAluResult),
    .inStoreData(inStoreData),
    .inDest(inDest),
    .inMemRead(inMemRead),
    .inMemWrite(inMemWrite),
    .inSize(inSize),
    .inSigned(inSigned),
    .stall(stall),
    .memReqValid(memReqValid),
    .memReqReady(memReqReady),
    .memReqWrite(memReqWrite),
    .memReqAddr(memReqAddr),
    .memReqByteEn(memReqByteEn),
    .memReqData(memReqData),
    .memRespValid(memRespValid),
    .memRespData(memRespData),
    .outValid(outValid),
    .outResult(outResult),
    .outDest(outDest),
    .outFault(outFault),
    .hazDest(hazDest),
    .hazLoadPending(hazLoadPending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] dest, input logic rd, input logic wr,
                       input logic [1:0] size, input logic sgn);
    inValid     = v;
    inAluResult = alu;
    inStoreData = sd;
    inDest      = dest;
    inMemRead   = rd;
    inMemWrite  = wr;
    inSize      = size;
    inSigned    = sgn;
  endtask

  task automatic idle_in();
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  // Full access with immediate ready and a response in the first WAIT cycle.
  task automatic run_access(input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] dest,
                            input logic rd, input logic wr, input logic [1:0] size, input logic sgn,
                            input logic [31:0] resp, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_res,
                            input logic [4:0] exp_dest);
    logic [31:0] exp_v;
    exp_q.push_back(exp_res);
    drive(1'b1, addr, sd, dest, rd, wr, size, sgn);
    #1;
    check("acc_stall_capture", stall, 1);
    tick();
    idle_in();
    #1;
    check("acc_req_valid", memReqValid, 1);
    check("acc_req_addr", memReqAddr, exp_addr);
    check("acc_req_be", memReqByteEn, exp_be);
    check("acc_req_data", memReqData, exp_wdata);
    check("acc_req_write", memReqWrite, wr);
    check("acc_haz_pending", hazLoadPending, rd & ~wr);
    memReqReady = 1'b1;
    tick();
    memReqReady  = 1'b0;
    memRespValid = 1'b1;
    memRespData  = resp;
    #1;
    check("acc_wait_stall", stall, 1);
    tick();
    memRespValid = 1'b0;
    #1;
    exp_v = exp_q.pop_front();
    check("acc_out_valid", outValid, 1);
    check("acc_out_result", outResult, exp_v);
    check("acc_out_dest", outDest, exp_dest);
    check("acc_out_fault", outFault, 0);
    check("acc_stall_drop", stall, 0);
    tick();
    check("acc_out_pulse", outValid, 0);
  endtask

  initial begin
    // reset state
    idle_in();
    tick();
    tick();
    check("rst_stall", stall, 0);
    check("rst_req_valid", memReqValid, 0);
    check("rst_out_valid", outValid, 0);
    check("rst_out_result", outResult, 0);
    check("rst_haz_pending", hazLoadPending, 0);
    check("rst_req_addr", memReqAddr, 0);
    rst = 1'b0;
    tick();

    // non-memory pass-through
    drive(1'b1, 32'hDEAD_BEEF, 32'd0, 5'd7, 1'b0, 1'b0, 2'd2, 1'b0);
    #1;
    check("pass_stall_now", stall, 0);
    tick();
    idle_in();
    #1;
    check("pass_valid", outValid, 1);
    check("pass_result", outResult, 32'hDEAD_BEEF);
    check("pass_dest", outDest, 7);
    check("pass_stall", stall, 0);
    tick();
    check("pass_valid_drop", outValid, 0);

    // signed byte load, ready after 2 cycles, response 3 cycles after handshake
    drive(1'b1, 32'h0000_1003, 32'd0, 5'd9, 1'b1, 1'b0, 2'd0, 1'b1);
    #1;
    check("lb_stall_capture", stall, 1);
    check("lb_haz_pending", hazLoadPending, 1);
    check("lb_haz_dest", hazDest, 9);
    tick();
    idle_in();
    #1;
    check("lb_req_valid", memReqValid, 1);
    check("lb_req_addr", memReqAddr, 32'h0000_1000);
    check("lb_req_be", memReqByteEn, 4'b1000);
    check("lb_req_write", memReqWrite, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("lb_req_hold", memReqValid, 1);
      check("lb_req_hold_addr", memReqAddr, 32'h0000_1000);
      check("lb_issue_stall", stall, 1);
    end
    memReqReady = 1'b1;
    tick();
    memReqReady = 1'b0;
    #1;
    check("lb_wait_req_valid", memReqValid, 0);
    check("lb_wait_stall", stall, 1);
    check("lb_wait_haz", hazLoadPending, 1);
    check("lb_wait_haz_dest", hazDest, 9);
    tick();
    tick();
    check("lb_no_early_out", outValid, 0);
    memRespValid = 1'b1;
    memRespData  = 32'h80FF_0000;
    #1;
    check("lb_resp_stall", stall, 1);
    tick();
    memRespValid = 1'b0;
    #1;
    check("lb_out_valid", outValid, 1);
    check("lb_out_result", outResult, 32'hFFFF_FF80);
    check("lb_out_dest", outDest, 9);
    check("lb_out_fault", outFault, 0);
    check("lb_stall_drop", stall, 0);
    check("lb_haz_clear", hazLoadPending, 0);
    tick();

    // stores and further loads
    run_access(32'h0000_2002, 32'h1234_ABCD, 5'd5, 1'b0, 1'b1, 2'd1, 1'b0, 32'd0,
               32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'd0, 5'd0);
    run_access(32'h0000_5002, 32'd0, 5'd6, 1'b1, 1'b0, 2'd1, 1'b0, 32'h8001_7FFF,
               32'h0000_5000, 4'b1100, 32'd0, 32'h0000_8001, 5'd6);
    run_access(32'h0000_5000, 32'd0, 5'd6, 1'b1, 1'b0, 2'd1, 1'b1, 32'h1234_8001,
               32'h0000_5000, 4'b0011, 32'd0, 32'hFFFF_8001, 5'd6);
    run_access(32'h0000_5001, 32'd0, 5'd8, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_F700,
               32'h0000_5000, 4'b0010, 32'd0, 32'h0000_00F7, 5'd8);
    run_access(32'h0000_6001, 32'h0000_00A5, 5'd12, 1'b1, 1'b1, 2'd0, 1'b0, 32'd0,
               32'h0000_6000, 4'b0010, 32'hA5A5_A5A5, 32'd0, 5'd0);
    run_access(32'h0000_6004, 32'd0, 5'd2, 1'b1, 1'b0, 2'd3, 1'b0, 32'hCAFE_F00D,
               32'h0000_6004, 4'b1111, 32'd0, 32'hCAFE_F00D, 5'd2);
    run_access(32'h0000_7008, 32'h0102_0304, 5'd13, 1'b0, 1'b1, 2'd2, 1'b0, 32'd0,
               32'h0000_7008, 4'b1111, 32'h0102_0304, 32'd0, 5'd0);

    // timeout after 4 WAIT cycles, late response ignored
    drive(1'b1, 32'h0000_4000, 32'd0, 5'd3, 1'b1, 1'b0, 2'd2, 1'b0);
    tick();
    idle_in();
    memReqReady = 1'b1;
    tick();
    memReqReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_wait_no_out", outValid, 0);
      check("to_wait_stall", stall, 1);
    end
    tick();
    check("to_out_valid", outValid, 1);
    check("to_out_fault", outFault, 1);
    check("to_out_dest", outDest, 0);
    check("to_stall_drop", stall, 0);
    memRespValid = 1'b1;
    memRespData  = 32'h5555_5555;
    tick();
    memRespValid = 1'b0;
    #1;
    check("to_late_valid", outValid, 0);
    check("to_late_fault", outFault, 0);
    check("to_late_stall", stall, 0);
    check("to_late_req", memReqValid, 0);
    tick();

    // misaligned word load at 0x3001
`ifdef MIPS_STAGE_MEM_ALIGN_CHECK_EN
    drive(1'b1, 32'h0000_3001, 32'd0, 5'd4, 1'b1, 1'b0, 2'd2, 1'b0);
    #1;
    check("mis_stall_now", stall, 1);
    check("mis_haz", hazLoadPending, 0);
    tick();
    idle_in();
    #1;
    check("mis_no_req", memReqValid, 0);
    check("mis_out_valid", outValid, 1);
    check("mis_out_fault", outFault, 1);
    check("mis_out_dest", outDest, 0);
    check("mis_stall_drop", stall, 0);
    tick();
`else
    run_access(32'h0000_3001, 32'd0, 5'd4, 1'b1, 1'b0, 2'd2, 1'b0, 32'h1122_3344,
               32'h0000_3000, 4'b1111, 32'd0, 32'h1122_3344, 5'd4);
`endif

    // reset in the middle of an outstanding load
    drive(1'b1, 32'h0000_7000, 32'd0, 5'd11, 1'b1, 1'b0, 2'd2, 1'b0);
    tick();
    idle_in();
    memReqReady = 1'b1;
    tick();
    memReqReady = 1'b0;
    check("rw_haz_before", hazLoadPending, 1);
    check("rw_stall_before", stall, 1);
    rst = 1'b1;
    #1;
    check("rw_stall", stall, 0);
    check("rw_req_valid", memReqValid, 0);
    check("rw_haz", hazLoadPending, 0);
    check("rw_haz_dest", hazDest, 0);
    check("rw_out_valid", outValid, 0);
    tick();
    rst = 1'b0;
    tick();
    check("rw_after_out", outValid, 0);
    check("rw_after_stall", stall, 0);

    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
